gray_fifo_ctrl: RTL and testbench
=================================

// Module: gray_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller that sequences a pair of Gray-coded pointers (write/read) around an external
//  2^AW-entry synchronous RAM. Provides valid/ready handshakes on both sides, RAM address/enable strobes,
//  fill level, and Gray pointer snapshots that slower-domain monitors can sample glitch-free.
//  Sits between a producer, a dual-port RAM and a first-word-fall-through consumer.
// PARAMETERS
//  AW    4   RAM address width; depth = 2**AW; pointers are AW+1 bits (extra wrap bit)
//  AF    12  almost-full threshold, level >= AF (only with GRAY_FIFO_ALMOST_EN)
//  AE    2   almost-empty threshold, level <= AE (only with GRAY_FIFO_ALMOST_EN)
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  areset       in   1     reset, asynchronous, active-low
//  clr          in   1     synchronous flush, highest priority after reset
//  wr_valid     in   1     producer has data
//  wr_ready     out  1     FIFO can accept (= !full)
//  rd_valid     out  1     ram_rdata holds head entry
//  rd_ready     in   1     consumer takes head entry
//  ram_we       out  1     RAM write strobe (= wr_valid & wr_ready)
//  ram_waddr    out  AW    RAM write address
//  ram_raddr    out  AW    RAM read address, 1-cycle registered read assumed
//  level        out  AW+1  committed entries, 0..2**AW
//  wptr_gray    out  AW+1  registered Gray write pointer
//  rptr_gray    out  AW+1  registered Gray read pointer
//  almost_full  out  1     only with GRAY_FIFO_ALMOST_EN
//  almost_empty out  1     only with GRAY_FIFO_ALMOST_EN
// BEHAVIOUR
//  - Reset (areset=0): pointers 0, level 0, wr_ready 1, rd_valid 0, ram_we 0, gray outputs 0.
//  - clr=1 at an edge: same values as reset; wr/rd handshakes in that cycle are ignored.
//  - Pointers: binary wbin/rbin, AW+1 bits, modulo 2**(AW+1) wrap. Gray = bin ^ (bin>>1), registered;
//    exactly one bit changes per increment, including at the wrap from 2**(AW+1)-1 to 0.
//  - full  = wbin[AW]!=rbin[AW] && wbin[AW-1:0]==rbin[AW-1:0]; empty = wbin==rbin.
//  - Write accept at edge N when wr_valid & wr_ready: RAM written at ram_waddr=wbin[AW-1:0], wbin++.
//  - Read side is FWFT. pop = rd_valid & rd_ready. ram_raddr = (pop ? rbin+1 : rbin)[AW-1:0], combinational.
//  - rd_valid is registered: next = (wbin != rbin_next), where rbin_next = rbin + pop.
//  - First-word latency: write accepted at edge N gives rd_valid=1 after edge N+1, with ram_rdata valid then.
//  - level = wbin - rbin, AW+1-bit subtraction; +1 on write-only, -1 on pop-only, unchanged when both.
//  - Simultaneous push & pop:
//      when full, wr_ready=0, so push is refused even if a pop occurs in the same cycle (no bypass);
//      when empty, rd_valid=0, so there is no pop.
//  - rd_valid & !rd_ready: head and ram_raddr held stable; rd_valid never drops without a pop.
//  - wr_valid while full: no RAM write, no pointer change, no error flag; the producer holds its data.
// CONFIGURATION
//  GRAY_FIFO_ALMOST_EN defined: almost_full/almost_empty ports exist, registered from next level.
//    Reset value: almost_full=0, almost_empty=1.
//  Undefined: ports, AF and AE logic absent; all other behaviour identical.
// STRUCTURE
//  Package gray_fifo_pkg: function bin2gray(), localparam helper for DEPTH, level width.
//  Sub-module gray_ptr (inc, clr, areset, clk -> bin, gray), instantiated twice for write and read.
// TESTING (AW=2, depth 4)
//  1. Release reset, idle 3 cycles -> level=0, wr_ready=1, rd_valid=0, wptr_gray=rptr_gray=000.
//  2. 4 writes, no reads -> level=4, wr_ready=0. 5th wr_valid -> ram_we=0, wbin unchanged.
//  3. Write D0 at edge N -> rd_valid=1 after N+1 with ram_raddr=0. Pop -> rd_valid=0, level=0.
//  4. 20 push/pop cycles at level 2 -> level stays 2; wptr_gray follows 000,001,011,010,110,111,101,100,000
//     with Hamming distance 1 per step.
//  5. Full (level 4) with push+pop in the same cycle -> pop only, level=3, wr_ready=1 the next cycle.
//  6. clr at level 3 mid-stream -> next cycle level=0, rd_valid=0, pointers 0.
//     With GRAY_FIFO_ALMOST_EN, AF=3, AE=1: almost_full=1 at level 3, almost_empty=1 at level <=1.

Source files
------------

// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the Gray-pointer FIFO controller.
//   bin2gray() : binary to reflected Gray code, evaluated at PTR_MAX_W bits;
//                callers cast the result down to their pointer width.
//   depth_of() : number of RAM entries for a given address width.
//   level_w()  : width of pointers and of the fill level (one extra wrap bit).
package gray_fifo_pkg;

  localparam int PTR_MAX_W = 16;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int level_w(input int aw);
    return aw + 1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr.sv
// One FIFO pointer: AW+1-bit binary counter plus its registered Gray image.
// Ports:
//   clk, areset (async, active-low), clr (sync flush to 0), inc (advance by one)
//   bin  : binary pointer, wraps modulo 2**(AW+1)
//   gray : Gray code of bin, registered so it never glitches for slow samplers
import gray_fifo_pkg::*;

module gray_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] bin,
  output logic [AW:0] gray
);

  localparam int PW = level_w(AW);

  logic [AW:0] bin_next;

  always_comb begin
    bin_next = bin;
    if (clr)
      bin_next = '0;
    else if (inc)
      bin_next = bin + PW'(1);
  end

  // Gray is computed from the next binary value so both registers update
  // on the same edge and stay in lockstep.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= PW'(bin2gray(PTR_MAX_W'(bin_next)));
    end
  end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO controller driving an external 2**AW-entry RAM with a
// one-cycle registered read port. First-word-fall-through read side.
// Optional feature macro: GRAY_FIFO_ALMOST_EN (adds almost_full/almost_empty
// and the AF/AE thresholds).
// Ports:
//   clk, areset (async, active-low), clr (sync flush)
//   wr_valid/wr_ready     : producer handshake, wr_ready = !full
//   rd_valid/rd_ready     : consumer handshake, rd_valid means RAM data is head
//   ram_we, ram_waddr     : RAM write strobe and address
//   ram_raddr             : RAM read address (combinational look-ahead)
//   level                 : committed entries 0..2**AW
//   wptr_gray, rptr_gray  : registered Gray pointers for other clock domains
//   almost_full/empty     : registered threshold flags (macro only)
import gray_fifo_pkg::*;

module gray_fifo_ctrl #(
  parameter int AW = 4
`ifdef GRAY_FIFO_ALMOST_EN
  ,
  parameter int AF = 12,
  parameter int AE = 2
`endif
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          clr,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [AW:0]   level,
`ifdef GRAY_FIFO_ALMOST_EN
  output logic          almost_full,
  output logic          almost_empty,
`endif
  output logic [AW:0]   wptr_gray,
  output logic [AW:0]   rptr_gray
);

  localparam int PW = level_w(AW);

  logic [AW:0] wbin;
  logic [AW:0] rbin;
  logic [AW:0] rbin_step;
  logic        full;
  logic        pop;
  logic        pop_ok;

  assign full      = (wbin[AW] != rbin[AW]) && (wbin[AW-1:0] == rbin[AW-1:0]);
  assign wr_ready  = !full;
  assign ram_we    = wr_valid & wr_ready & !clr;
  assign ram_waddr = wbin[AW-1:0];

  // Read address looks one entry ahead on a pop so the registered RAM read
  // presents the new head right after the edge that consumed the old one.
  assign pop       = rd_valid & rd_ready;
  assign pop_ok    = pop & !clr;
  assign rbin_step = rbin + PW'(pop);
  assign ram_raddr = rbin_step[AW-1:0];

  assign level     = wbin - rbin;

  gray_ptr #(.AW(AW)) u_wptr (
    .clk    (clk),
    .areset (areset),
    .clr    (clr),
    .inc    (ram_we),
    .bin    (wbin),
    .gray   (wptr_gray)
  );

  gray_ptr #(.AW(AW)) u_rptr (
    .clk    (clk),
    .areset (areset),
    .clr    (clr),
    .inc    (pop_ok),
    .bin    (rbin),
    .gray   (rptr_gray)
  );

  // Compared against the current wbin, not its next value: a word written at
  // edge N is only readable from the RAM after edge N+1.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset)
      rd_valid <= 1'b0;
    else if (clr)
      rd_valid <= 1'b0;
    else
      rd_valid <= (wbin != rbin_step);
  end

`ifdef GRAY_FIFO_ALMOST_EN
  localparam logic [AW:0] AF_L = AF[AW:0];
  localparam logic [AW:0] AE_L = AE[AW:0];

  logic [AW:0] level_next;

  always_comb begin
    level_next = (wbin + PW'(ram_we)) - rbin_step;
    if (clr)
      level_next = '0;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_next >= AF_L);
      almost_empty <= (level_next <= AE_L);
    end
  end
`endif

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
module tb_gray_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          clr = 1'b0;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready;
  logic          rd_valid;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [AW:0]   level;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
`ifdef GRAY_FIFO_ALMOST_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_fifo_ctrl #(
    .AW(AW)
`ifdef GRAY_FIFO_ALMOST_EN
    , .AF(3), .AE(1)
`endif
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .clr          (clr),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_raddr    (ram_raddr),
    .level        (level),
`ifdef GRAY_FIFO_ALMOST_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .wptr_gray    (wptr_gray),
    .rptr_gray    (rptr_gray)
  );

  // External RAM with one-cycle registered read.
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_rdata;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= wr_data;
    ram_rdata <= mem[ram_raddr];
  end

  // Reference model: a queue of stored words plus write/read totals.
  logic [7:0] q[$];
  int  wcnt = 0;
  int  rcnt = 0;
  bit  m_rdv = 0;
  bit  m_af = 0;
  bit  m_ae = 1;
  bit  chk_en = 0;
  logic [2:0] gray_tbl [8];

  initial begin
    gray_tbl[0] = 3'b000; gray_tbl[1] = 3'b001; gray_tbl[2] = 3'b011; gray_tbl[3] = 3'b010;
    gray_tbl[4] = 3'b110; gray_tbl[5] = 3'b111; gray_tbl[6] = 3'b101; gray_tbl[7] = 3'b100;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge areset) begin
    if (!areset) begin
      q.delete();
      wcnt = 0; rcnt = 0; m_rdv = 0; m_af = 0; m_ae = 1;
    end else if (clr) begin
      q.delete();
      wcnt = 0; rcnt = 0; m_rdv = 0; m_af = 0; m_ae = 1;
    end else begin
      bit pop_m, push_m;
      pop_m  = m_rdv && rd_ready;
      push_m = wr_valid && (q.size() < DEPTH);
      m_rdv  = (q.size() - int'(pop_m)) != 0;
      if (pop_m) begin void'(q.pop_front()); rcnt++; end
      if (push_m) begin q.push_back(wr_data); wcnt++; end
      m_af = (q.size() >= 3);
      m_ae = (q.size() <= 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit pop_m;
      pop_m = m_rdv && rd_ready;
      chk("level", 32'(level), 32'(q.size()));
      chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      chk("ram_we", 32'(ram_we), 32'(wr_valid && (q.size() < DEPTH) && !clr));
      chk("ram_waddr", 32'(ram_waddr), 32'(wcnt % DEPTH));
      chk("ram_raddr", 32'(ram_raddr), 32'((rcnt + int'(pop_m)) % DEPTH));
      chk("wptr_gray", 32'(wptr_gray), 32'(gray_tbl[wcnt % 8]));
      chk("rptr_gray", 32'(rptr_gray), 32'(gray_tbl[rcnt % 8]));
`ifdef GRAY_FIFO_ALMOST_EN
      chk("almost_full", 32'(almost_full), 32'(m_af));
      chk("almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
      if (m_rdv && q.size() > 0)
        chk("head_data", 32'(ram_rdata), 32'(q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] prev_g;
    int         wphase;
    int         rphase;

    repeat (2) tick();
    areset = 1'b1;
    chk_en = 1;

    // 1: idle after reset
    repeat (3) tick();
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_wr_ready", 32'(wr_ready), 32'd1);
    chk("t1_rd_valid", 32'(rd_valid), 32'd0);
    chk("t1_gray", 32'({wptr_gray, rptr_gray}), 32'd0);

    // 2: fill, then a refused fifth write
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin wr_data = 8'(8'hA0 + i); tick(); end
    chk("t2_level", 32'(level), 32'd4);
    chk("t2_wr_ready", 32'(wr_ready), 32'd0);
    chk("t2_ram_we", 32'(ram_we), 32'd0);
    chk("t2_wptr_gray", 32'(wptr_gray), 32'b110);
    tick();
    chk("t2_wptr_held", 32'(wptr_gray), 32'b110);
    chk("t2_waddr_held", 32'(ram_waddr), 32'd0);

    // 5: push+pop while full pops only
    rd_ready = 1'b1;
    chk("t5_no_bypass", 32'(ram_we), 32'd0);
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("t5_level", 32'(level), 32'd3);
    chk("t5_wr_ready", 32'(wr_ready), 32'd1);
`ifdef GRAY_FIFO_ALMOST_EN
    chk("t6_af_lvl3", 32'(almost_full), 32'd1);
    chk("t6_ae_lvl3", 32'(almost_empty), 32'd0);
`endif

    // 6: flush at level 3
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_gray", 32'({wptr_gray, rptr_gray}), 32'd0);
`ifdef GRAY_FIFO_ALMOST_EN
    chk("t6_af_clr", 32'(almost_full), 32'd0);
    chk("t6_ae_clr", 32'(almost_empty), 32'd1);
`endif

    // 3: first-word latency and pop to empty
    wr_valid = 1'b1; wr_data = 8'h5D; tick(); wr_valid = 1'b0;
    chk("t3_rd_valid_N", 32'(rd_valid), 32'd0);
    chk("t3_level_N", 32'(level), 32'd1);
    tick();
    chk("t3_rd_valid_N1", 32'(rd_valid), 32'd1);
    chk("t3_raddr", 32'(ram_raddr), 32'd0);
    chk("t3_rdata", 32'(ram_rdata), 32'h5D);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("t3_rd_valid_pop", 32'(rd_valid), 32'd0);
    chk("t3_level_pop", 32'(level), 32'd0);

    // 4: steady push/pop at level 2 (wbin starts at 3)
    wr_valid = 1'b1;
    repeat (2) begin wr_data = 8'($urandom); tick(); end
    rd_ready = 1'b1;
    prev_g = wptr_gray;
    chk("t4_start_gray", 32'(prev_g), 32'(gray_tbl[3]));
    for (int i = 1; i <= 20; i++) begin
      wr_data = 8'($urandom);
      tick();
      chk("t4_level", 32'(level), 32'd2);
      chk("t4_gray_seq", 32'(wptr_gray), 32'(gray_tbl[(3 + i) % 8]));
      chk("t4_hamming", 32'($countones(wptr_gray ^ prev_g)), 32'd1);
      prev_g = wptr_gray;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;

    // Random traffic with shifting bias and occasional flushes
    for (int i = 0; i < 1500; i++) begin
      wphase = (i < 500) ? 3 : (i < 1000) ? 1 : 2;
      rphase = (i < 500) ? 1 : (i < 1000) ? 3 : 2;
      wr_valid = ($urandom_range(0, 3) < wphase);
      rd_ready = ($urandom_range(0, 3) < rphase);
      clr      = ($urandom_range(0, 63) == 0);
      wr_data  = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b0; clr = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
